// File: rtl/ddr3_axi_retime_buf_pkg.sv
// Shared definitions for the DDR3 AXI retime buffers: channel payload widths,
// FSM state encoding and packet-mode selectors.
package ddr3_axi_retime_buf_pkg;

  localparam int WCMD_W  = 46;
  localparam int WDATA_W = 37;
  localparam int WRESP_W = 6;
  localparam int RREQ_W  = 46;
  localparam int RRESP_W = 39;

  localparam logic [0:0] ST_GATHER      = 1'b0;
  localparam logic [0:0] ST_CUT_THROUGH = 1'b1;

  localparam int MODE_STREAM = 0;
  localparam int MODE_PACKET = 1;

endpackage

// File: rtl/ddr3_axi_retime_buf_ram.sv
// DEPTH x (WIDTH+1) storage for the retime buffer: registered write port,
// asynchronous read port, no reset on the array contents.
module ddr3_axi_retime_buf_ram
  import ddr3_axi_retime_buf_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH:0]    wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH:0]    rd_data
);

  logic [WIDTH:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ddr3_axi_retime_buf.sv
// Parametrised AXI channel retime buffer with occupancy/almost-full reporting,
// synchronous flush and an optional store-and-forward (packet) mode.
module ddr3_axi_retime_buf
  import ddr3_axi_retime_buf_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 2,
  parameter int PACKET_MODE = MODE_STREAM,
  parameter int AFULL_LEVEL = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic              last_i,
  input  logic              push_i,
  output logic              accept_o,
  output logic [WIDTH-1:0]  data_out_o,
  output logic              last_o,
  output logic              valid_o,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [ADDR_W:0]   level_o,
  output logic              afull_o,
  output logic [ADDR_W:0]   pkt_count_o
);

  localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_THR  = (ADDR_W+1)'(AFULL_LEVEL);
  localparam logic [ADDR_W:0]   LVL_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   pkt_count;
  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [WIDTH:0]    head;
  logic              push_fire;
  logic              pop_fire;
  logic              push_last;
  logic              pop_last;

  assign push_fire = push_i & accept_o;
  assign pop_fire  = pop_i & valid_o;
  assign push_last = push_fire & last_i;
  assign pop_last  = pop_fire & last_o;

  assign accept_o    = (level != FULL_LEVEL) & ~flush_i;
  assign afull_o     = level >= AFULL_THR;
  assign level_o     = level;
  assign pkt_count_o = pkt_count;
  assign data_out_o  = head[WIDTH-1:0];
  assign last_o      = head[WIDTH];

  // In GATHER a burst is held back until its last beat lands, unless the
  // buffer fills first; that full-escape is what lets oversized bursts through.
  always_comb begin
    valid_o = 1'b0;
    if (PACKET_MODE == MODE_STREAM) begin
      valid_o = level != '0;
    end else if (state == ST_CUT_THROUGH) begin
      valid_o = level != '0;
    end else begin
      valid_o = (pkt_count != '0) | (level == FULL_LEVEL);
    end
  end

  always_comb begin
    state_next = state;
    if (PACKET_MODE == MODE_STREAM) begin
      state_next = ST_GATHER;
    end else if (state == ST_GATHER) begin
      if (pop_fire && pkt_count == '0 && !last_o) state_next = ST_CUT_THROUGH;
    end else begin
      if (pop_last) state_next = ST_GATHER;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level <= '0;
    end else if (flush_i) begin
      level <= '0;
    end else begin
      case ({push_fire, pop_fire})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pkt_count <= '0;
    end else if (flush_i) begin
      pkt_count <= '0;
    end else begin
      case ({push_last, pop_last})
        2'b10:   pkt_count <= pkt_count + LVL_ONE;
        2'b01:   pkt_count <= pkt_count - LVL_ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_GATHER;
    end else if (flush_i) begin
      state <= ST_GATHER;
    end else begin
      state <= state_next;
    end
  end

  ddr3_axi_retime_buf_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (push_fire),
    .wr_addr (wr_ptr),
    .wr_data ({last_i, data_in_i}),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

endmodule
